// File: rtl/saed_stim_pkg.sv
// Shared types and constants for the OAI21 power-characterisation stimulus block.
package saed_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_APPLY_FROM = 2'd1,
        ST_APPLY_TO   = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

    localparam int          NUM_VEC   = 8;
    localparam int          NUM_PHASE = 128;
    localparam logic [6:0]  NO_FAIL   = 7'h7F;

    // Expected QN of an ideal OAI21 for input vector v = {IN3, IN2, IN1}.
    function automatic logic oai21_golden(input logic [2:0] v);
        return ~((v[0] | v[1]) & v[2]);
    endfunction

endpackage

// File: rtl/stim_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones instead of wrapping.
module stim_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rstb,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count qualifying events, clear on request, stop at the maximum value.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/oai21_power_stim.sv
// Sweeps all 64 (from,to) vector transitions into an OAI21 cell, counts QN toggles
// and end-of-phase mismatches against the ideal OAI21 function.
module oai21_power_stim
    import saed_stim_pkg::*;
#(
    parameter int HOLD  = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rstb,
    input  logic             i_start,
    input  logic             i_qn,
    output logic             o_in1,
    output logic             o_in2,
    output logic             o_in3,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_toggle_cnt,
    output logic [CNT_W-1:0] o_mismatch_cnt,
    output logic [6:0]       o_first_fail
);

    localparam int         VEC_W      = $clog2(NUM_VEC);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD - 1);
    localparam logic [6:0] LAST_PHASE = 7'(NUM_PHASE - 1);

    state_t           r_state;
    logic [VEC_W-1:0] r_f;
    logic [VEC_W-1:0] r_t;
    logic [7:0]       r_hold;
    logic             r_qn_prev;
    logic [6:0]       r_first_fail;

    logic             w_busy;
    logic             w_start;
    logic             w_phase_end;
    logic             w_mismatch;
    logic             w_toggle;
    logic [2:0]       w_vec;
    logic [6:0]       w_phase;

    assign w_busy      = (r_state == ST_APPLY_FROM) || (r_state == ST_APPLY_TO);
    assign w_start     = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_vec       = (r_state == ST_APPLY_FROM) ? r_f :
                         (r_state == ST_APPLY_TO)   ? r_t : 3'd0;
    // Phase index 2*(8*f+t) + (APPLY_TO ? 1 : 0) falls out of a plain concatenation.
    assign w_phase     = {r_f, r_t, (r_state == ST_APPLY_TO)};
    assign w_phase_end = w_busy && (r_hold == 8'd0);
    assign w_mismatch  = w_phase_end && (i_qn != oai21_golden(w_vec));
    assign w_toggle    = w_busy && (i_qn != r_qn_prev);

    // Sweep sequencer: phase walk, hold countdown, QN history and first-failure capture.
    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            r_state      <= ST_IDLE;
            r_f          <= '0;
            r_t          <= '0;
            r_hold       <= 8'd0;
            r_qn_prev    <= 1'b1;
            r_first_fail <= NO_FAIL;
        end else if (w_start) begin
            // qn_prev returns to its reset value so every sweep is judged from the same baseline.
            r_state      <= ST_APPLY_FROM;
            r_f          <= '0;
            r_t          <= '0;
            r_hold       <= HOLD_LAST;
            r_qn_prev    <= 1'b1;
            r_first_fail <= NO_FAIL;
        end else if (w_busy) begin
            r_qn_prev <= i_qn;
            // A first failure in phase 127 latches 7'h7F, which is indistinguishable anyway.
            if (w_mismatch && (r_first_fail == NO_FAIL)) begin
                r_first_fail <= w_phase;
            end
            if (r_hold != 8'd0) begin
                r_hold <= r_hold - 8'd1;
            end else begin
                r_hold <= HOLD_LAST;
                if (w_phase == LAST_PHASE) begin
                    r_state <= ST_DONE;
                    r_f     <= '0;
                    r_t     <= '0;
                end else if (r_state == ST_APPLY_FROM) begin
                    r_state <= ST_APPLY_TO;
                end else begin
                    r_state    <= ST_APPLY_FROM;
                    {r_f, r_t} <= {r_f, r_t} + 6'd1;
                end
            end
        end
    end

    stim_sat_counter #(.CNT_W(CNT_W)) u_toggle_cnt (
        .i_clk   (i_clk),
        .i_rstb  (i_rstb),
        .i_clear (w_start),
        .i_inc   (w_toggle),
        .o_count (o_toggle_cnt)
    );

    stim_sat_counter #(.CNT_W(CNT_W)) u_mismatch_cnt (
        .i_clk   (i_clk),
        .i_rstb  (i_rstb),
        .i_clear (w_start),
        .i_inc   (w_mismatch),
        .o_count (o_mismatch_cnt)
    );

    assign o_in1        = w_vec[0];
    assign o_in2        = w_vec[1];
    assign o_in3        = w_vec[2];
    assign o_busy       = w_busy;
    assign o_done       = (r_state == ST_DONE);
    assign o_first_fail = r_first_fail;

endmodule

// File: tb/tb_oai21_power_stim.sv
// Scoreboard bench: two DUT configurations driven by a fault-injectable OAI21 cell model.
module tb_oai21_power_stim;

    typedef struct {
        int tog;
        int mis;
        int ff;
        int busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       start4 = 1'b0;
    logic       start2 = 1'b0;
    logic [7:0] mask = 8'h00;

    logic       in1_4, in2_4, in3_4, busy4, done4, qn4;
    logic [7:0] tog4, mis4;
    logic [6:0] ff4;
    logic       in1_2, in2_2, in3_2, busy2, done2, qn2;
    logic [3:0] tog2, mis2;
    logic [6:0] ff2;

    exp_t q4[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Cell model: ideal OAI21 with per-vector output inversion given by mask.
    function automatic logic golden_bit(input int v);
        bit a = (v % 2) == 1;
        bit b = ((v / 2) % 2) == 1;
        bit c = v >= 4;
        return ((a || b) && c) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic cell_qn(input logic [7:0] m, input int v);
        return golden_bit(v) ^ m[v];
    endfunction

    assign qn4 = cell_qn(mask, int'({in3_4, in2_4, in1_4}));
    assign qn2 = cell_qn(mask, int'({in3_2, in2_2, in1_2}));

    // Expected sweep outcome computed from the phase list directly.
    function automatic exp_t model(input logic [7:0] m, input int hold, input int cnt_w);
        exp_t e;
        int   maxc;
        logic prev;
        bit   found;
        maxc   = (1 << cnt_w) - 1;
        e.tog  = 0;
        e.mis  = 0;
        e.ff   = 127;
        e.busy = 128 * hold;
        prev   = 1'b1;
        found  = 0;
        for (int p = 0; p < 128; p++) begin
            int   pair;
            int   v;
            logic g;
            logic q;
            pair = p / 2;
            v    = (p % 2 == 0) ? pair / 8 : pair % 8;
            g    = golden_bit(v);
            q    = g ^ m[v];
            for (int h = 0; h < hold; h++) begin
                if (q != prev && e.tog < maxc) e.tog++;
                prev = q;
            end
            if (q != g) begin
                if (e.mis < maxc) e.mis++;
                if (!found) begin
                    found = 1;
                    e.ff  = p;
                end
            end
        end
        return e;
    endfunction

    oai21_power_stim #(.HOLD(4), .CNT_W(8)) u_dut4 (
        .i_clk          (clk),
        .i_rstb         (rstb),
        .i_start        (start4),
        .i_qn           (qn4),
        .o_in1          (in1_4),
        .o_in2          (in2_4),
        .o_in3          (in3_4),
        .o_busy         (busy4),
        .o_done         (done4),
        .o_toggle_cnt   (tog4),
        .o_mismatch_cnt (mis4),
        .o_first_fail   (ff4)
    );

    oai21_power_stim #(.HOLD(2), .CNT_W(4)) u_dut2 (
        .i_clk          (clk),
        .i_rstb         (rstb),
        .i_start        (start2),
        .i_qn           (qn2),
        .o_in1          (in1_2),
        .o_in2          (in2_2),
        .o_in3          (in3_2),
        .o_busy         (busy2),
        .o_done         (done2),
        .o_toggle_cnt   (tog2),
        .o_mismatch_cnt (mis2),
        .o_first_fail   (ff2)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor for the HOLD=4 instance: measures BUSY length, scores results at each DONE rise.
    initial begin : mon4
        int   busy_cnt;
        logic prev_done;
        exp_t e;
        busy_cnt  = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstb) begin
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (busy4) busy_cnt++;
                if (done4 && !prev_done) begin
                    check("dut4 expectation pending", int'(q4.size() > 0), 1);
                    if (q4.size() > 0) begin
                        e = q4.pop_front();
                        check("dut4 toggle_cnt",   int'(tog4), e.tog);
                        check("dut4 mismatch_cnt", int'(mis4), e.mis);
                        check("dut4 first_fail",   int'(ff4),  e.ff);
                        check("dut4 busy cycles",  busy_cnt,   e.busy);
                    end
                    busy_cnt = 0;
                end
                prev_done = done4;
            end
        end
    end

    // Monitor for the HOLD=2, CNT_W=4 instance.
    initial begin : mon2
        int   busy_cnt;
        logic prev_done;
        exp_t e;
        busy_cnt  = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstb) begin
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (busy2) busy_cnt++;
                if (done2 && !prev_done) begin
                    check("dut2 expectation pending", int'(q2.size() > 0), 1);
                    if (q2.size() > 0) begin
                        e = q2.pop_front();
                        check("dut2 toggle_cnt",   int'(tog2), e.tog);
                        check("dut2 mismatch_cnt", int'(mis2), e.mis);
                        check("dut2 first_fail",   int'(ff2),  e.ff);
                        check("dut2 busy cycles",  busy_cnt,   e.busy);
                    end
                    busy_cnt = 0;
                end
                prev_done = done2;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, " dut4 vector"}, int'({in3_4, in2_4, in1_4}), 0);
        check({tag, " dut4 busy"},   int'(busy4), 0);
        check({tag, " dut4 done"},   int'(done4), 0);
        check({tag, " dut4 toggle"}, int'(tog4), 0);
        check({tag, " dut4 mism"},   int'(mis4), 0);
        check({tag, " dut4 ff"},     int'(ff4), 127);
        check({tag, " dut2 busy"},   int'(busy2), 0);
        check({tag, " dut2 ff"},     int'(ff2), 127);
    endtask

    // Pulse START on both instances and check the cleared state one edge later.
    task automatic start_sweep(input logic [7:0] m);
        mask = m;
        @(negedge clk);
        start4 = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        start2 = 1'b0;
        check("start dut4 busy",   int'(busy4), 1);
        check("start dut4 done",   int'(done4), 0);
        check("start dut4 toggle", int'(tog4), 0);
        check("start dut4 mism",   int'(mis4), 0);
        check("start dut4 ff",     int'(ff4), 127);
        check("start dut4 vector", int'({in3_4, in2_4, in1_4}), 0);
        check("start dut2 busy",   int'(busy2), 1);
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!(done4 && done2) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("sweep finished within budget", int'(done4 && done2), 1);
        check("dut4 vector idle after sweep", int'({in3_4, in2_4, in1_4}), 0);
    endtask

    task automatic push_model(input logic [7:0] m);
        q4.push_back(model(m, 4, 8));
        q2.push_back(model(m, 2, 4));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rstb = 1'b1;
        @(negedge clk);

        // Ideal cell.
        q4.push_back('{tog: 59, mis: 0, ff: 127, busy: 512});
        q2.push_back('{tog: 15, mis: 0, ff: 127, busy: 256});
        start_sweep(8'h00);
        wait_done();

        // QN stuck at 1, started from DONE.
        q4.push_back('{tog: 0, mis: 48, ff: 11, busy: 512});
        q2.push_back('{tog: 0, mis: 15, ff: 11, busy: 256});
        start_sweep(8'hE0);
        wait_done();

        // Sweep aborted by reset at cycle 100; no result expected.
        start_sweep(8'hE0);
        repeat (98) @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        check_reset_state("mid-sweep reset");
        rstb = 1'b1;

        // Ideal sweep with extra START pulses that must be ignored.
        q4.push_back('{tog: 59, mis: 0, ff: 127, busy: 512});
        q2.push_back('{tog: 15, mis: 0, ff: 127, busy: 256});
        start_sweep(8'h00);
        repeat (8) @(negedge clk);
        start4 = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        start2 = 1'b0;
        repeat (189) @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (99) @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done();

        // Ideal sweep again from DONE: must reproduce the first result.
        q4.push_back('{tog: 59, mis: 0, ff: 127, busy: 512});
        q2.push_back('{tog: 15, mis: 0, ff: 127, busy: 256});
        start_sweep(8'h00);
        wait_done();

        // Randomised fault patterns against the reference model.
        for (int i = 0; i < 4; i++) begin
            logic [7:0] m;
            m = 8'($urandom);
            push_model(m);
            start_sweep(m);
            wait_done();
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check("dut4 scoreboard drained", q4.size(), 0);
        check("dut2 scoreboard drained", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
